// File: rtl/sr_dff_pipe_if.sv
// Data/qualifier bundle for sr_dff_pipe: stage-0 inputs, CE and last-stage outputs.
// Latency: n/a (pure wiring).
// Backpressure: none; CE is the only hold control and it stalls the whole pipe.
interface sr_dff_pipe_if #(
  parameter int WIDTH = 8
);
  logic             CE;       // clock enable, pipeline advances only when high
  logic [WIDTH-1:0] D;        // data into stage 0
  logic             VLD_IN;   // qualifier travelling alongside D
  logic [WIDTH-1:0] Q;        // last-stage data
  logic [WIDTH-1:0] QN;       // bitwise inverse of Q
  logic             VLD_OUT;  // last-stage valid tag

  // Driver side: produces data and enable, observes the pipeline output.
  modport master (
    output CE,
    output D,
    output VLD_IN,
    input  Q,
    input  QN,
    input  VLD_OUT
  );

  // Pipeline side: consumes data and enable, produces the registered output.
  modport slave (
    input  CE,
    input  D,
    input  VLD_IN,
    output Q,
    output QN,
    output VLD_OUT
  );
endinterface

// File: rtl/sr_dff_pipe.sv
// WIDTH x DEPTH set/reset flop pipeline with valid tag and true/inverted outputs.
// Latency: DEPTH CE-qualified rising CLK edges from D to Q; async RESETN/SETN act at once.
// Backpressure: none; CE=0 freezes all data and valid state. Scan via SR_DFF_PIPE_SCAN_EN.
module sr_dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             SETN,
`ifdef SR_DFF_PIPE_SCAN_EN
  input  logic             SE,
  input  logic             SI,
  output logic             SO,
`endif
  sr_dff_pipe_if.slave     bus
);

  // Stage storage; stage[0] sits in the low WIDTH bits, which also gives the
  // scan chain order directly when the vector is viewed flat.
  logic [DEPTH-1:0][WIDTH-1:0] r_stage;
  logic [DEPTH-1:0]            r_vld;

  logic [DEPTH-1:0][WIDTH-1:0] w_pipe_nxt;
  logic [DEPTH-1:0]            w_vld_nxt;

  // Set request masked by reset. While RESETN is low this is forced high so
  // reset wins; when RESETN rises with SETN still low it falls, giving the
  // flops a fresh set event so they move to SET_VAL without a clock.
  logic w_setn;
  assign w_setn = SETN | ~RESETN;

  // Normal shift: D enters stage 0, every other stage takes its predecessor.
  always_comb begin
    w_pipe_nxt    = r_stage;
    w_vld_nxt     = r_vld;
    w_pipe_nxt[0] = bus.D;
    w_vld_nxt[0]  = bus.VLD_IN;
    for (int i = 1; i < DEPTH; i++) begin
      w_pipe_nxt[i] = r_stage[i-1];
      w_vld_nxt[i]  = r_vld[i-1];
    end
  end

`ifdef SR_DFF_PIPE_SCAN_EN
  // Scan shift: one bit per edge from SI through stage[0] bit 0 up to the
  // MSB of the last stage, which drives SO.
  logic [DEPTH*WIDTH-1:0] w_flat;
  logic [DEPTH*WIDTH-1:0] w_scan_nxt;
  assign w_flat = r_stage;

  always_comb begin
    w_scan_nxt    = w_flat;
    w_scan_nxt[0] = SI;
    for (int k = 1; k < DEPTH*WIDTH; k++) begin
      w_scan_nxt[k] = w_flat[k-1];
    end
  end

  // Data flops: async reset, then async set, then scan shift, then CE shift.
  always_ff @(posedge CLK or negedge RESETN or negedge w_setn) begin
    if (!RESETN) begin
      r_stage <= '0;
    end else if (!w_setn) begin
      r_stage <= {DEPTH{SET_VAL}};
    end else if (SE) begin
      r_stage <= w_scan_nxt;
    end else if (bus.CE) begin
      r_stage <= w_pipe_nxt;
    end
  end

  // Valid flops: cleared by either async control, held during scan.
  always_ff @(posedge CLK or negedge RESETN or negedge w_setn) begin
    if (!RESETN) begin
      r_vld <= '0;
    end else if (!w_setn) begin
      r_vld <= '0;
    end else if (!SE && bus.CE) begin
      r_vld <= w_vld_nxt;
    end
  end

  // Chain tail is the MSB of the last stage, already a flop output.
  assign SO = r_stage[DEPTH-1][WIDTH-1];
`else
  // Data flops: async reset, then async set, then CE-qualified shift.
  always_ff @(posedge CLK or negedge RESETN or negedge w_setn) begin
    if (!RESETN) begin
      r_stage <= '0;
    end else if (!w_setn) begin
      r_stage <= {DEPTH{SET_VAL}};
    end else if (bus.CE) begin
      r_stage <= w_pipe_nxt;
    end
  end

  // Valid flops: cleared by either async control, advance with the data.
  always_ff @(posedge CLK or negedge RESETN or negedge w_setn) begin
    if (!RESETN) begin
      r_vld <= '0;
    end else if (!w_setn) begin
      r_vld <= '0;
    end else if (bus.CE) begin
      r_vld <= w_vld_nxt;
    end
  end
`endif

  // Outputs come from the last stage flops only; nothing combinational from D.
  assign bus.Q       = r_stage[DEPTH-1];
  assign bus.QN      = ~r_stage[DEPTH-1];
  assign bus.VLD_OUT = r_vld[DEPTH-1];

endmodule

// File: tb/tb_sr_dff_pipe.sv
// Directed bench for sr_dff_pipe at WIDTH=8, DEPTH=3, SET_VAL=8'hA5.
// Latency: expects Q after 3 CE-qualified edges.
// Backpressure: exercises CE hold and async abort.
module tb_sr_dff_pipe;

  logic CLK;
  logic RESETN;
  logic SETN;
`ifdef SR_DFF_PIPE_SCAN_EN
  logic SE;
  logic SI;
  logic SO;
`endif

  int checks;
  int errors;

  sr_dff_pipe_if #(.WIDTH(8)) bus ();

  sr_dff_pipe #(
    .WIDTH   (8),
    .DEPTH   (3),
    .SET_VAL (8'hA5)
  ) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .SETN   (SETN),
`ifdef SR_DFF_PIPE_SCAN_EN
    .SE     (SE),
    .SI     (SI),
    .SO     (SO),
`endif
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    SETN   = 1'b0;
    #2;
    checks++; if (bus.Q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", bus.Q); end
    checks++; if (bus.QN !== 8'hFF) begin errors++; $display("FAIL reset_qn got=%h exp=FF", bus.QN); end
    checks++; if (bus.VLD_OUT !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", bus.VLD_OUT); end
    @(negedge CLK);
    RESETN = 1'b1;
    #1;
    checks++; if (bus.Q !== 8'hA5) begin errors++; $display("FAIL set_after_reset_q got=%h exp=A5", bus.Q); end
    checks++; if (bus.QN !== 8'h5A) begin errors++; $display("FAIL set_after_reset_qn got=%h exp=5A", bus.QN); end
    checks++; if (bus.VLD_OUT !== 1'b0) begin errors++; $display("FAIL set_after_reset_vld got=%b exp=0", bus.VLD_OUT); end
    #1;
    SETN = 1'b1;
    #1;
    checks++; if (bus.Q !== 8'hA5) begin errors++; $display("FAIL set_release_q got=%h exp=A5", bus.Q); end
  endtask

  task automatic test_latency();
    bus.CE = 1'b1;
    bus.VLD_IN = 1'b1;
    bus.D = 8'h11; step();
    bus.D = 8'h22; step();
    checks++; if (bus.Q !== 8'hA5 || bus.VLD_OUT !== 1'b0) begin errors++; $display("FAIL lat_edge2 got=%h/%b exp=A5/0", bus.Q, bus.VLD_OUT); end
    bus.D = 8'h33; step();
    checks++; if (bus.Q !== 8'h11 || bus.VLD_OUT !== 1'b1) begin errors++; $display("FAIL lat_edge3 got=%h/%b exp=11/1", bus.Q, bus.VLD_OUT); end
    checks++; if (bus.QN !== 8'hEE) begin errors++; $display("FAIL lat_edge3_qn got=%h exp=EE", bus.QN); end
    bus.D = 8'h44; step();
    checks++; if (bus.Q !== 8'h22 || bus.VLD_OUT !== 1'b1) begin errors++; $display("FAIL lat_edge4 got=%h/%b exp=22/1", bus.Q, bus.VLD_OUT); end
    bus.D = 8'h00; bus.VLD_IN = 1'b0; step();
    checks++; if (bus.Q !== 8'h33 || bus.VLD_OUT !== 1'b1) begin errors++; $display("FAIL lat_edge5 got=%h/%b exp=33/1", bus.Q, bus.VLD_OUT); end
    step();
    checks++; if (bus.Q !== 8'h44 || bus.VLD_OUT !== 1'b1) begin errors++; $display("FAIL lat_edge6 got=%h/%b exp=44/1", bus.Q, bus.VLD_OUT); end
    step();
    checks++; if (bus.Q !== 8'h00 || bus.VLD_OUT !== 1'b0) begin errors++; $display("FAIL lat_flush got=%h/%b exp=00/0", bus.Q, bus.VLD_OUT); end
  endtask

  task automatic test_enable_hold();
    bus.CE = 1'b1;
    bus.D = 8'h11; bus.VLD_IN = 1'b1; step();
    bus.CE = 1'b0;
    bus.D = 8'hFF; bus.VLD_IN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.Q !== 8'h00 || bus.VLD_OUT !== 1'b0) begin errors++; $display("FAIL hold_edge%0d got=%h/%b exp=00/0", i, bus.Q, bus.VLD_OUT); end
    end
    bus.CE = 1'b1;
    step();
    checks++; if (bus.Q !== 8'h00 || bus.VLD_OUT !== 1'b0) begin errors++; $display("FAIL hold_resume1 got=%h/%b exp=00/0", bus.Q, bus.VLD_OUT); end
    step();
    checks++; if (bus.Q !== 8'h11 || bus.VLD_OUT !== 1'b1) begin errors++; $display("FAIL hold_resume2 got=%h/%b exp=11/1", bus.Q, bus.VLD_OUT); end
  endtask

  task automatic test_async_abort();
    bus.CE = 1'b1;
    bus.D = 8'h55; bus.VLD_IN = 1'b1;
    step();
    step();
    #2;
    SETN = 1'b0;
    #1;
    checks++; if (bus.Q !== 8'hA5 || bus.VLD_OUT !== 1'b0) begin errors++; $display("FAIL abort_set got=%h/%b exp=A5/0", bus.Q, bus.VLD_OUT); end
    checks++; if (bus.QN !== 8'h5A) begin errors++; $display("FAIL abort_qn got=%h exp=5A", bus.QN); end
    SETN = 1'b1;
    bus.VLD_IN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.VLD_OUT !== 1'b0) begin errors++; $display("FAIL abort_vld_edge%0d got=%b exp=0", i, bus.VLD_OUT); end
    end
    checks++; if (bus.Q !== 8'h55) begin errors++; $display("FAIL abort_refill got=%h exp=55", bus.Q); end
  endtask

  task automatic test_bubble();
    bus.CE = 1'b1;
    bus.D = 8'h77; bus.VLD_IN = 1'b0; step();
    bus.D = 8'h88; bus.VLD_IN = 1'b1; step();
    bus.D = 8'h00; bus.VLD_IN = 1'b0; step();
    checks++; if (bus.Q !== 8'h77 || bus.VLD_OUT !== 1'b0) begin errors++; $display("FAIL bubble_77 got=%h/%b exp=77/0", bus.Q, bus.VLD_OUT); end
    step();
    checks++; if (bus.Q !== 8'h88 || bus.VLD_OUT !== 1'b1) begin errors++; $display("FAIL bubble_88 got=%h/%b exp=88/1", bus.Q, bus.VLD_OUT); end
    step();
    checks++; if (bus.Q !== 8'h00 || bus.VLD_OUT !== 1'b0) begin errors++; $display("FAIL bubble_00 got=%h/%b exp=00/0", bus.Q, bus.VLD_OUT); end
  endtask

  task automatic test_reset_midflight();
    bus.CE = 1'b1;
    bus.D = 8'h3C; bus.VLD_IN = 1'b1;
    step(); step(); step();
    checks++; if (bus.Q !== 8'h3C || bus.VLD_OUT !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%h/%b exp=3C/1", bus.Q, bus.VLD_OUT); end
    #2;
    RESETN = 1'b0;
    #1;
    checks++; if (bus.Q !== 8'h00 || bus.QN !== 8'hFF || bus.VLD_OUT !== 1'b0) begin errors++; $display("FAIL midrst got=%h/%h/%b exp=00/FF/0", bus.Q, bus.QN, bus.VLD_OUT); end
    RESETN = 1'b1;
    #1;
    checks++; if (bus.Q !== 8'h00) begin errors++; $display("FAIL midrst_release got=%h exp=00", bus.Q); end
  endtask

`ifdef SR_DFF_PIPE_SCAN_EN
  task automatic test_scan();
    #1;
    RESETN = 1'b0;
    #1;
    RESETN = 1'b1;
    bus.CE = 1'b1;
    bus.VLD_IN = 1'b1;
    bus.D = 8'hFF;
    SE = 1'b1;
    SI = 1'b1;
    step();
    SI = 1'b0;
    for (int i = 0; i < 22; i++) step();
    checks++; if (SO !== 1'b0) begin errors++; $display("FAIL scan_edge23 got=%b exp=0", SO); end
    step();
    checks++; if (SO !== 1'b1) begin errors++; $display("FAIL scan_edge24 got=%b exp=1", SO); end
    checks++; if (bus.VLD_OUT !== 1'b0) begin errors++; $display("FAIL scan_vld got=%b exp=0", bus.VLD_OUT); end
    step();
    checks++; if (SO !== 1'b0 || bus.Q !== 8'h00) begin errors++; $display("FAIL scan_edge25 got=%b/%h exp=0/00", SO, bus.Q); end
    SE = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    bus.CE = 1'b0;
    bus.D = 8'h00;
    bus.VLD_IN = 1'b0;
`ifdef SR_DFF_PIPE_SCAN_EN
    SE = 1'b0;
    SI = 1'b0;
`endif
    test_reset();
    test_latency();
    test_enable_hold();
    test_async_abort();
    test_bubble();
    test_reset_midflight();
`ifdef SR_DFF_PIPE_SCAN_EN
    test_scan();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_dff_pipe.md
# sr_dff_pipe

Parametrised multi-bit, multi-stage flop pipeline with asynchronous active-low reset, an asynchronous active-low set, clock enable and valid tracking. Each stage has the same behaviour as the single-bit set/reset DFF cell, generalised in width and depth, and drives both true and inverted outputs. It is used for retiming datapaths and control vectors that need a defined power-on value in either polarity. An optional scan chain is available for DFT.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 2, number of pipeline stages (≥1)
- SET_VAL, {WIDTH{1'b1}}, value loaded into every stage while SETN is low
- CLK  input  1  clock, rising-edge active
- RESETN  input  1  reset, asynchronous, active-low
- SETN  input  1  async set, active-low; loads SET_VAL
- CE  input  1  clock enable; pipeline advances only when high
- D  input  WIDTH  data into stage 0
- VLD_IN  input  1  qualifier for D
- Q  output  WIDTH  data of last stage
- QN  output  WIDTH  bitwise inverse of Q
- VLD_OUT  output  1  valid bit of last stage
- SE, SI  input  1 each  scan enable and scan in (SR_DFF_PIPE_SCAN_EN only)
- SO  output  1  scan out (SR_DFF_PIPE_SCAN_EN only)

## Operation
- State: stage[0..DEPTH-1] of WIDTH bits each, and vld[0..DEPTH-1].
- Async priority is RESETN low, then SETN low, then clocked behaviour.
- RESETN low: all stages are 0 and all vld are 0, immediately with no clock needed. Q=0, QN=all ones, VLD_OUT=0.
- SETN low with RESETN high: all stages are SET_VAL and all vld are 0, immediately. Q=SET_VAL, QN=~SET_VAL.
- Both low: the reset result applies. If SETN is still low when RESETN rises, the stages switch to SET_VAL asynchronously.
- On a CLK rising edge with both released and CE=1:
  - stage[0]←D and vld[0]←VLD_IN;
  - stage[i]←stage[i-1] and vld[i]←vld[i-1].
- CE=0: all state is held, including vld.
- Data moves regardless of VLD_IN. vld is only a tag and never gates data capture.
- Q=stage[DEPTH-1], QN=~Q, VLD_OUT=vld[DEPTH-1]. Outputs come straight from flops, with no combinational path from D.
- DEPTH=1 behaves as a single WIDTH-bit set/reset flop.

## Timing
- Latency is DEPTH CE-qualified rising edges from D to Q. Edges with CE=0 do not count.
- An async assert changes outputs within the same delta. No clock edge is needed.
- After release of RESETN or SETN, the first rising CLK edge with CE=1 captures normally.
  - No internal synchronizer is provided.
  - The release must meet recovery time to CLK. A release coincident with a CLK edge is a timing violation and its result is unspecified; benches must avoid it.
- An async assert mid-pipeline discards all in-flight data. VLD_OUT drops in the same delta.

## Configuration
- SR_DFF_PIPE_SCAN_EN defined: the SE, SI and SO ports exist.
  - With SE=1, each rising CLK edge, ignoring CE, shifts one bit along a serial chain of DEPTH×WIDTH bits.
  - Chain order: SI → stage[0] bit 0 → … → stage[0] bit WIDTH-1 → stage[1] bit 0 → … → stage[DEPTH-1] bit WIDTH-1 → SO.
  - vld is held during scan and is not part of the chain.
  - Async RESETN and SETN still override scan.
  - SE=0 gives normal operation.
- SR_DFF_PIPE_SCAN_EN undefined: SE, SI and SO are absent and there is no scan logic.

## Test plan
WIDTH=8, DEPTH=3, SET_VAL=8'hA5 for all scenarios.

- Reset/set priority:
  - RESETN=0, SETN=0 → Q=00, QN=FF, VLD_OUT=0.
  - RESETN→1 with SETN=0 → Q=A5 and QN=5A immediately, no clock edge.
  - SETN→1 → Q stays A5 until clocked.
- Latency: with CE=1, drive D=11,22,33,44 with VLD_IN=1 on consecutive edges → Q=11 and VLD_OUT=1 after the 3rd edge, then 22, 33, 44 on the following edges.
- Enable hold: D=11 with VLD_IN=1 on one edge, then 5 edges with CE=0 → Q and VLD_OUT unchanged. The 2 further CE=1 edges give Q=11.
- Async abort mid-flight: after 2 edges of valid data, pulse SETN low between edges → Q=A5 and VLD_OUT=0 at once. The next 3 CE edges with VLD_IN=0 keep VLD_OUT=0.
- Bubble tagging: D=77 with VLD_IN=0 → Q=77 after 3 edges with VLD_OUT=0.
- Scan (SCAN_EN build): after reset, with SE=1, shift SI=1 for 1 edge then SI=0 for 23 edges → SO=1 on the 24th edge (chain length 24). vld is unchanged throughout and Q=00 afterwards.
